adapter_to_bus_var: RTL

- Parametrised successor to the fixed 128->32 bus adapter.
- Buffers up to DEPTH wide messages and serialises each one onto a narrow OWIDTH push channel, least-significant beat first.
- Each message carries its own beat count (variable length), and the final beat of each message is tagged with last.
- Provides an AtB-style clear method that flushes all buffered state; sits between a request/indication producer and the Out2InLast-style bus sink.

---
 rtl/adapter_to_bus_var.sv | 94 +++++++++
 1 files changed

// File: rtl/adapter_to_bus_var.sv
// adapter_to_bus_var: buffers wide messages and serialises them as OWIDTH beats with last; ADAPTER_TO_BUS_STATS_EN adds stat_msgs/stat_beats counters
module adapter_to_bus_var #(
  parameter int WIDTH = 128,
  parameter int OWIDTH = 32,
  parameter int DEPTH = 2,
  localparam int BEATS = WIDTH / OWIDTH,
  localparam int LENW = $clog2(BEATS) + 1
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              in_enq__ENA,
  output logic              in_enq__RDY,
  input  logic [WIDTH-1:0]  in_enq_v,
  input  logic [LENW-1:0]   in_enq_length,
  output logic              out_enq__ENA,
  input  logic              out_enq__RDY,
  output logic [OWIDTH-1:0] out_enq_v,
  output logic              out_enq_last,
  input  logic              clear__ENA,
  output logic              clear__RDY
`ifdef ADAPTER_TO_BUS_STATS_EN
  ,
  output logic [31:0]       stat_msgs,
  output logic [31:0]       stat_beats
`endif
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int BW = BEATS > 1 ? $clog2(BEATS) : 1;
  if (WIDTH % OWIDTH != 0 || DEPTH < 1) begin : g_bad_params
    $error("adapter_to_bus_var: WIDTH must be a multiple of OWIDTH and DEPTH >= 1");
  end
  logic [WIDTH-1:0]  mem_v [DEPTH];
  logic [LENW-1:0]   mem_n [DEPTH];
  logic [OWIDTH-1:0] lanes [BEATS];
  logic [PW-1:0]     rd, wr;
  logic [CW-1:0]     cnt;
  logic [BW-1:0]     beat;
  logic [LENW-1:0]   len_n;
  logic              busy, push, pop;
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return p == PW'(DEPTH - 1) ? '0 : p + PW'(1);
  endfunction
  assign clear__RDY = 1'b1;
  assign busy = cnt != '0;
  assign in_enq__RDY = cnt < CW'(DEPTH);
  assign out_enq__ENA = busy && out_enq__RDY;
  always_comb begin
    for (int i = 0; i < BEATS; i++) lanes[i] = mem_v[rd][i*OWIDTH +: OWIDTH];
  end
  assign out_enq_v = busy ? lanes[beat] : '0;
  assign out_enq_last = busy && LENW'(beat) == mem_n[rd] - LENW'(1);
  assign pop = out_enq__ENA && out_enq_last;
  assign push = in_enq__ENA && in_enq__RDY && !clear__ENA;
  assign len_n = (in_enq_length == '0 || in_enq_length > LENW'(BEATS)) ? LENW'(BEATS) : in_enq_length;
  always_ff @(posedge CLK) begin
    if (push) begin
      mem_v[wr] <= in_enq_v;
      mem_n[wr] <= len_n;
    end
  end
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      cnt  <= '0;
      rd   <= '0;
      wr   <= '0;
      beat <= '0;
    end else if (clear__ENA) begin
      cnt  <= '0;
      rd   <= '0;
      wr   <= '0;
      beat <= '0;
    end else begin
      if (push) wr <= inc(wr);
      if (pop) rd <= inc(rd);
      if (out_enq__ENA) beat <= out_enq_last ? '0 : beat + BW'(1);
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  end
`ifdef ADAPTER_TO_BUS_STATS_EN
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stat_msgs  <= '0;
      stat_beats <= '0;
    end else if (clear__ENA) begin
      stat_msgs  <= '0;
      stat_beats <= '0;
    end else if (out_enq__ENA) begin
      stat_beats <= stat_beats + 32'd1;
      stat_msgs  <= stat_msgs + 32'(out_enq_last);
    end
  end
`endif
endmodule
